// File: rtl/lcd_text_feeder.sv
// Streams a two-line text buffer to a character-LCD controller as DDRAM-address
// commands and character writes, pacing each transaction with a fixed idle gap.
module lcd_text_feeder #(
   parameter int unsigned COLS = 16,
   parameter int unsigned GAP  = 520,
   parameter int unsigned AW   = $clog2(COLS) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_char,
   input  logic          refresh,
   input  logic          lcd_busy,
   output logic          lcd_enable,
   output logic [9:0]    lcd_bus,
   output logic          active,
   output logic          done
);

   localparam int unsigned IW = $clog2(2 * COLS + 2);
   localparam int unsigned BW = $clog2(2 * COLS);
   localparam int unsigned GW = $clog2(GAP + 1);
   localparam int unsigned CW = AW - 1;

   localparam logic [IW-1:0] LastIdx  = IW'(2 * COLS + 1);
   localparam logic [IW-1:0] Line1Idx = IW'(COLS + 1);
   localparam logic [IW-1:0] ColsIdx  = IW'(COLS);
   localparam logic [GW-1:0] GapLast  = GW'(GAP - 1);

   typedef enum logic [1:0] {StIdle, StWaitRdy, StIssue, StGap} state_e;

   state_e        state_q;
   logic [IW-1:0] idx_q;
   logic [GW-1:0] gap_cnt_q;
   logic          pending_q;

   logic [7:0]    buf_q [2*COLS];

   logic          wr_line;
   logic [CW-1:0] wr_col;
   logic          wr_ok;
   logic [BW-1:0] wr_ptr;
   logic [BW-1:0] rd_ptr;
   logic [9:0]    bus_next;

   always_comb begin
      wr_line = wr_addr[AW-1];
      wr_col  = wr_addr[CW-1:0];
      wr_ok   = 32'(wr_col) < COLS;
      wr_ptr  = BW'(wr_line ? (COLS + 32'(wr_col)) : 32'(wr_col));
      // Line 0 characters sit at idx 1..COLS, line 1 characters two slots later.
      rd_ptr  = (idx_q <= ColsIdx) ? BW'(idx_q - IW'(1)) : BW'(idx_q - IW'(2));
      if (idx_q == '0) begin
         bus_next = 10'h080;
      end else if (idx_q == Line1Idx) begin
         bus_next = 10'h0C0;
      end else begin
         bus_next = {2'b10, buf_q[rd_ptr]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2 * COLS; i++) begin
            buf_q[i] <= 8'h20;
         end
      end else if (wr_en && wr_ok) begin
         buf_q[wr_ptr] <= wr_char;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         gap_cnt_q  <= '0;
         pending_q  <= 1'b0;
         lcd_enable <= 1'b0;
         lcd_bus    <= 10'h000;
         active     <= 1'b0;
         done       <= 1'b0;
      end else begin
         lcd_enable <= 1'b0;
         done       <= 1'b0;
         // Requests during a pass collapse into a single follow-up pass.
         if (state_q != StIdle && refresh) begin
            pending_q <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (refresh || pending_q) begin
                  state_q   <= StWaitRdy;
                  idx_q     <= '0;
                  pending_q <= 1'b0;
                  active    <= 1'b1;
               end
            end
            StWaitRdy: begin
               if (!lcd_busy) begin
                  state_q    <= StIssue;
                  lcd_enable <= 1'b1;
                  lcd_bus    <= bus_next;
               end
            end
            StIssue: begin
               gap_cnt_q <= '0;
               state_q   <= StGap;
            end
            StGap: begin
               if (gap_cnt_q == GapLast) begin
                  if (idx_q == LastIdx) begin
                     state_q <= StIdle;
                     done    <= 1'b1;
                     active  <= 1'b0;
                  end else begin
                     idx_q   <= idx_q + IW'(1);
                     state_q <= StWaitRdy;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + GW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Directed bench for lcd_text_feeder: a monitor logs every transaction and done pulse,
// and each scenario task compares the log against hand-computed values.
module tb_lcd_text_feeder;

   localparam int unsigned COLS = 16;
   localparam int unsigned GAP  = 520;
   localparam int unsigned AW   = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [7:0]    wr_char = '0;
   logic          refresh = 1'b0;
   logic          lcd_busy = 1'b0;
   logic          lcd_enable;
   logic [9:0]    lcd_bus;
   logic          active;
   logic          done;

   int checks = 0;
   int failures = 0;

   int         cyc = 0;
   int         n_tx = 0;
   int         n_done = 0;
   int         last_done_cyc = 0;
   logic [9:0] tx_bus [256];
   int         tx_cyc [256];

   lcd_text_feeder #(.COLS(COLS), .GAP(GAP), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_char    (wr_char),
      .refresh    (refresh),
      .lcd_busy   (lcd_busy),
      .lcd_enable (lcd_enable),
      .lcd_bus    (lcd_bus),
      .active     (active),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Samples 2 time units after each rising edge, clear of the negedge stimulus.
   always @(posedge clk) begin
      #2;
      cyc = cyc + 1;
      if (lcd_enable) begin
         if (n_tx < 256) begin
            tx_bus[n_tx] = lcd_bus;
            tx_cyc[n_tx] = cyc;
         end
         n_tx = n_tx + 1;
      end
      if (done) begin
         n_done = n_done + 1;
         last_done_cyc = cyc;
      end
   end

   task automatic write_char(input logic [AW-1:0] a, input logic [7:0] c);
      @(negedge clk);
      wr_en = 1'b1;
      wr_addr = a;
      wr_char = c;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_tx(input int target, input int limit);
      int k = 0;
      while (n_tx < target && k < limit) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic wait_done(input int target, input int limit);
      int k = 0;
      while (n_done < target && k < limit) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (lcd_enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", lcd_enable); end
      checks++; if (lcd_bus !== 10'h000) begin failures++; $display("FAIL reset_bus got=%h exp=000", lcd_bus); end
      checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (n_tx !== 0) begin failures++; $display("FAIL reset_no_tx got=%0d exp=0", n_tx); end
   endtask

   task automatic test_default_pass;
      int base = n_tx;
      int dbase = n_done;
      int t0;
      logic [9:0] exp;
      @(negedge clk);
      refresh = 1'b1;
      t0 = cyc;
      @(negedge clk);
      refresh = 1'b0;
      wait_tx(base + 1, 10);
      checks++; if (active !== 1'b1) begin failures++; $display("FAIL default_active got=%b exp=1", active); end
      wait_done(dbase + 1, 20000);
      repeat (5) @(negedge clk);
      checks++; if (n_done - dbase !== 1) begin failures++; $display("FAIL default_done_count got=%0d exp=1", n_done - dbase); end
      checks++; if (n_tx - base !== 34) begin failures++; $display("FAIL default_tx_count got=%0d exp=34", n_tx - base); end
      checks++; if (tx_cyc[base] - t0 !== 2) begin failures++; $display("FAIL default_latency got=%0d exp=2", tx_cyc[base] - t0); end
      for (int i = 0; i < 34; i++) begin
         exp = (i == 0) ? 10'h080 : (i == 17) ? 10'h0C0 : 10'h220;
         checks++;
         if (tx_bus[base + i] !== exp) begin
            failures++; $display("FAIL default_bus[%0d] got=%h exp=%h", i, tx_bus[base + i], exp);
         end
      end
      for (int i = 1; i < 34; i++) begin
         checks++;
         if (tx_cyc[base + i] - tx_cyc[base + i - 1] !== 522) begin
            failures++; $display("FAIL default_spacing[%0d] got=%0d exp=522", i,
                                 tx_cyc[base + i] - tx_cyc[base + i - 1]);
         end
      end
      checks++; if (last_done_cyc - tx_cyc[base + 33] !== 521) begin failures++; $display("FAIL default_done_timing got=%0d exp=521", last_done_cyc - tx_cyc[base + 33]); end
      checks++; if (active !== 1'b0) begin failures++; $display("FAIL default_active_after got=%b exp=0", active); end
   endtask

   task automatic test_write_pass;
      int base = n_tx;
      int dbase = n_done;
      write_char(5'h00, 8'h48);
      write_char(5'h1F, 8'h69);
      @(negedge clk);
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
      wait_tx(base + 6, 4000);
      // idx 2 already sent, idx 18 still pending in this pass
      write_char(5'h01, 8'h42);
      write_char(5'h10, 8'h41);
      wait_done(dbase + 1, 20000);
      repeat (5) @(negedge clk);
      checks++; if (n_tx - base !== 34) begin failures++; $display("FAIL write_tx_count got=%0d exp=34", n_tx - base); end
      checks++; if (tx_bus[base + 1] !== 10'h248) begin failures++; $display("FAIL write_bus1 got=%h exp=248", tx_bus[base + 1]); end
      checks++; if (tx_bus[base + 2] !== 10'h220) begin failures++; $display("FAIL write_bus2_sent got=%h exp=220", tx_bus[base + 2]); end
      checks++; if (tx_bus[base + 17] !== 10'h0C0) begin failures++; $display("FAIL write_bus17 got=%h exp=0c0", tx_bus[base + 17]); end
      checks++; if (tx_bus[base + 18] !== 10'h241) begin failures++; $display("FAIL write_bus18_late got=%h exp=241", tx_bus[base + 18]); end
      checks++; if (tx_bus[base + 33] !== 10'h269) begin failures++; $display("FAIL write_bus33 got=%h exp=269", tx_bus[base + 33]); end
   endtask

   task automatic test_multi_refresh;
      int base = n_tx;
      int dbase = n_done;
      int d;
      int gap_exp;
      @(negedge clk);
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
      wait_tx(base + 3, 3000);
      @(negedge clk); refresh = 1'b1; @(negedge clk); refresh = 1'b0;
      wait_tx(base + 10, 5000);
      @(negedge clk); refresh = 1'b1; @(negedge clk); refresh = 1'b0;
      wait_tx(base + 20, 6000);
      @(negedge clk); refresh = 1'b1; @(negedge clk); refresh = 1'b0;
      wait_done(dbase + 2, 30000);
      repeat (1000) @(negedge clk);
      checks++; if (n_done - dbase !== 2) begin failures++; $display("FAIL multi_done_count got=%0d exp=2", n_done - dbase); end
      checks++; if (n_tx - base !== 68) begin failures++; $display("FAIL multi_tx_count got=%0d exp=68", n_tx - base); end
      for (int i = 1; i < 68; i++) begin
         d = tx_cyc[base + i] - tx_cyc[base + i - 1];
         gap_exp = (i == 34) ? 523 : 522;
         checks++;
         if (d !== gap_exp) begin
            failures++; $display("FAIL multi_spacing[%0d] got=%0d exp=%0d", i, d, gap_exp);
         end
      end
      checks++; if (tx_bus[base + 34] !== 10'h080) begin failures++; $display("FAIL multi_pass2_bus0 got=%h exp=080", tx_bus[base + 34]); end
      checks++; if (tx_bus[base + 36] !== 10'h242) begin failures++; $display("FAIL multi_pass2_bus2 got=%h exp=242", tx_bus[base + 36]); end
      checks++; if (tx_bus[base + 67] !== 10'h269) begin failures++; $display("FAIL multi_pass2_bus33 got=%h exp=269", tx_bus[base + 67]); end
   endtask

   task automatic test_reset_mid_pass;
      int base = n_tx;
      @(negedge clk);
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
      wait_tx(base + 11, 7000);
      repeat (50) @(negedge clk);
      checks++; if (lcd_bus !== 10'h220) begin failures++; $display("FAIL midreset_bus_hold got=%h exp=220", lcd_bus); end
      checks++; if (active !== 1'b1) begin failures++; $display("FAIL midreset_active_before got=%b exp=1", active); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (lcd_bus !== 10'h000) begin failures++; $display("FAIL midreset_bus got=%h exp=000", lcd_bus); end
      checks++; if (active !== 1'b0) begin failures++; $display("FAIL midreset_active got=%b exp=0", active); end
      checks++; if (lcd_enable !== 1'b0) begin failures++; $display("FAIL midreset_enable got=%b exp=0", lcd_enable); end
      repeat (2000) @(negedge clk);
      checks++; if (n_tx - base !== 11) begin failures++; $display("FAIL midreset_no_more_tx got=%0d exp=11", n_tx - base); end
      checks++; if (active !== 1'b0) begin failures++; $display("FAIL midreset_active_later got=%b exp=0", active); end
   endtask

   task automatic test_busy_stall;
      int base = n_tx;
      int t1;
      lcd_busy = 1'b1;
      @(negedge clk);
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
      repeat (9400) @(negedge clk);
      checks++; if (n_tx - base !== 0) begin failures++; $display("FAIL busy_no_tx got=%0d exp=0", n_tx - base); end
      checks++; if (active !== 1'b1) begin failures++; $display("FAIL busy_active got=%b exp=1", active); end
      lcd_busy = 1'b0;
      t1 = cyc;
      wait_tx(base + 3, 1200);
      checks++; if (n_tx - base < 3) begin failures++; $display("FAIL busy_tx_timeout got=%0d exp=3", n_tx - base); end
      checks++; if (tx_cyc[base] - t1 !== 1) begin failures++; $display("FAIL busy_release_latency got=%0d exp=1", tx_cyc[base] - t1); end
      checks++; if (tx_bus[base] !== 10'h080) begin failures++; $display("FAIL busy_bus0 got=%h exp=080", tx_bus[base]); end
      // Buffer was cleared by the earlier reset, so the written characters are gone.
      checks++; if (tx_bus[base + 1] !== 10'h220) begin failures++; $display("FAIL busy_bus1_cleared got=%h exp=220", tx_bus[base + 1]); end
      checks++; if (tx_bus[base + 2] !== 10'h220) begin failures++; $display("FAIL busy_bus2_cleared got=%h exp=220", tx_bus[base + 2]); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_default_pass();
      test_write_pass();
      test_multi_refresh();
      test_reset_mid_pass();
      test_busy_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
